// File: rtl/coh_pkg.sv
// Shared definitions for the MSI coherence model: CDB word layout, MSI state
// encoding and the CDB arbiter state enum.
package coh_pkg;

  // Common data bus word width and the all-ones "nothing here" value
  localparam int unsigned CDB_W = 22;
  localparam logic [CDB_W-1:0] CDB_IDLE = '1;

  // MSI line states
  typedef enum logic [1:0] {
    MsiI = 2'b00,
    MsiS = 2'b01,
    MsiM = 2'b10
  } msi_e;

  // Field positions within an emit / CDB word
  localparam int unsigned TagLsb = 13;
  localparam int unsigned TagMsb = 15;

  // Field positions within a write-back word
  localparam int unsigned WbTagLsb  = 19;
  localparam int unsigned WbTagMsb  = 21;
  localparam int unsigned WbDataLsb = 0;
  localparam int unsigned WbDataMsb = 15;

  // CDB arbiter transaction phases
  typedef enum logic [1:0] {
    StIdle,
    StBcast,
    StSnoop,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches valid_i starting at ptr_i+1
// (mod N), wrapping, and returns the first valid entry.
//   valid_i : request vector
//   ptr_i   : index of the last winner (lowest priority this round)
//   gnt_o   : one-hot grant
//   idx_o   : binary index of the grant
//   any_o   : at least one request valid
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % N);
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_bus_arbiter.sv
// CDB arbiter: grants one processor emit at a time (round-robin), broadcasts
// it on cdb for a listen cycle and a respond cycle, then acks the requester
// and forwards any snooper write-back to memory.
//   clock/reset    : clock, async active-high reset
//   req_emit       : per-processor pending emit, IDLE_WORD = none
//   req_ack        : one-hot completion pulse
//   cdb            : broadcast bus, IDLE_WORD when idle
//   wb_en_in/_data : snooper write-back sampled at end of respond cycle
//   mem_we/_wdata  : one-cycle memory write
//   grant_id       : current / last granted processor
//   busy           : transaction in progress
//   wb_conflict    : sticky, multiple write-backs in one respond cycle
module cdb_bus_arbiter
  import coh_pkg::*;
#(
  parameter int unsigned   NPROC     = 2,
  parameter int unsigned   W         = CDB_W,
  parameter logic [W-1:0]  IDLE_WORD = '1,
  localparam int unsigned  IdxW      = (NPROC > 1) ? $clog2(NPROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NPROC*W-1:0]  req_emit,
  output logic [NPROC-1:0]    req_ack,
  output logic [W-1:0]        cdb,
  input  logic [NPROC-1:0]    wb_en_in,
  input  logic [NPROC*W-1:0]  wb_data_in,
  output logic                mem_we,
  output logic [W-1:0]        mem_wdata,
  output logic [IdxW-1:0]     grant_id,
  output logic                busy,
  output logic                wb_conflict
);

  arb_state_e state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [W-1:0]     cdb_q, cdb_d;
  logic [NPROC-1:0] ack_q, ack_d;
  logic             we_q, we_d;
  logic [W-1:0]     wdata_q, wdata_d;
  logic [IdxW-1:0]  gid_q, gid_d;
  logic             busy_q, busy_d;
  logic             conf_q, conf_d;

  logic [NPROC-1:0] valid;
  logic [NPROC-1:0] pick_gnt;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;
  logic [W-1:0]     pick_word;
  logic [NPROC-1:0] own_mask;
  logic [NPROC-1:0] wb_mask;
  logic [W-1:0]     wb_word;

  always_comb begin
    valid = '0;
    for (int i = 0; i < NPROC; i++) begin
      valid[i] = (req_emit[i*W +: W] != IDLE_WORD);
    end
  end

  rr_pick #(
    .N    (NPROC),
    .IdxW (IdxW)
  ) u_rr_pick (
    .valid_i (valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_word = IDLE_WORD;
    for (int i = 0; i < NPROC; i++) begin
      if (pick_gnt[i]) pick_word = req_emit[i*W +: W];
    end
  end

  // The granted processor cannot snoop its own request
  assign own_mask = NPROC'(1) << gid_q;
  assign wb_mask  = wb_en_in & ~own_mask;

  // Lowest-index write-back wins
  always_comb begin
    wb_word = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (wb_mask[i]) wb_word = wb_data_in[i*W +: W];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cdb_d    = cdb_q;
    ack_d    = '0;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    gid_d    = gid_q;
    conf_d   = conf_q;
    unique case (state_q)
      StIdle: begin
        cdb_d = IDLE_WORD;
        if (pick_any) begin
          cdb_d    = pick_word;  // cdb_q is the latched copy from here on
          gid_d    = pick_idx;
          rr_ptr_d = pick_idx;
          state_d  = StBcast;
        end
      end
      StBcast: state_d = StSnoop;
      StSnoop: begin
        cdb_d   = IDLE_WORD;
        ack_d   = own_mask;
        we_d    = |wb_mask;
        if (|wb_mask) wdata_d = wb_word;
        if ($countones(wb_mask) > 1) conf_d = 1'b1;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= IdxW'(NPROC - 1);
      cdb_q    <= IDLE_WORD;
      ack_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      gid_q    <= '0;
      busy_q   <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
      conf_q   <= conf_d;
    end
  end

  assign req_ack     = ack_q;
  assign cdb         = cdb_q;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign wb_conflict = conf_q;

endmodule

// File: tb/tb_cdb_bus_arbiter.sv
// Directed bench for cdb_bus_arbiter with NPROC=3. Each vector row gives the
// inputs for one cycle and the outputs expected just after the closing edge.
module tb_cdb_bus_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned W  = 22;

  localparam logic [W-1:0] IW = 22'h3FFFFF;
  localparam logic [W-1:0] W0 = 22'h002000;
  localparam logic [W-1:0] W1 = 22'h004001;
  localparam logic [W-1:0] W2 = 22'h006002;

  localparam logic [NP*W-1:0] EI   = {IW, IW, IW};
  localparam logic [NP*W-1:0] E0   = {IW, IW, W0};
  localparam logic [NP*W-1:0] E1   = {IW, W1, IW};
  localparam logic [NP*W-1:0] E2   = {W2, IW, IW};
  localparam logic [NP*W-1:0] E01  = {IW, W1, W0};
  localparam logic [NP*W-1:0] EALL = {W2, W1, W0};
  localparam logic [NP*W-1:0] WD0  = '0;
  localparam logic [NP*W-1:0] WD4  = {22'h0, 22'h0, 22'h00000A};
  localparam logic [NP*W-1:0] WD4B = {22'h0, 22'h0, 22'h081234};
  localparam logic [NP*W-1:0] WD5  = {22'h0, 22'h100055, 22'h080033};

  logic              clock;
  logic              reset;
  logic [NP*W-1:0]   req_emit;
  logic [NP-1:0]     req_ack;
  logic [W-1:0]      cdb;
  logic [NP-1:0]     wb_en_in;
  logic [NP*W-1:0]   wb_data_in;
  logic              mem_we;
  logic [W-1:0]      mem_wdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              wb_conflict;

  cdb_bus_arbiter #(
    .NPROC     (NP),
    .W         (W),
    .IDLE_WORD (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_emit    (req_emit),
    .req_ack     (req_ack),
    .cdb         (cdb),
    .wb_en_in    (wb_en_in),
    .wb_data_in  (wb_data_in),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .grant_id    (grant_id),
    .busy        (busy),
    .wb_conflict (wb_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string           nm;
    logic [NP*W-1:0] emit;
    logic [NP-1:0]   wben;
    logic [NP*W-1:0] wbd;
    logic [W-1:0]    cdb;
    logic [NP-1:0]   ack;
    logic            we;
    logic [W-1:0]    wdata;
    logic [1:0]      gid;
    logic            busy;
    logic            conf;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] o3;
  logic [W-1:0] w3;

  function automatic vec_t mk(input string nm, input logic [NP*W-1:0] e,
                              input logic [NP-1:0] wen, input logic [NP*W-1:0] wd,
                              input logic [W-1:0] c, input logic [NP-1:0] a,
                              input logic m, input logic [W-1:0] md,
                              input logic [1:0] g, input logic b, input logic cf);
    vec_t v;
    v.nm = nm; v.emit = e; v.wben = wen; v.wbd = wd; v.cdb = c; v.ack = a;
    v.we = m; v.wdata = md; v.gid = g; v.busy = b; v.conf = cf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    req_emit   = t.emit;
    wb_en_in   = t.wben;
    wb_data_in = t.wbd;
    @(posedge clock);
    #1;
    chk({t.nm, " cdb"},       64'(cdb),         64'(t.cdb));
    chk({t.nm, " req_ack"},   64'(req_ack),     64'(t.ack));
    chk({t.nm, " mem_we"},    64'(mem_we),      64'(t.we));
    chk({t.nm, " mem_wdata"}, 64'(mem_wdata),   64'(t.wdata));
    chk({t.nm, " grant_id"},  64'(grant_id),    64'(t.gid));
    chk({t.nm, " busy"},      64'(busy),        64'(t.busy));
    chk({t.nm, " conflict"},  64'(wb_conflict), 64'(t.conf));
  endtask

  // One full transaction: BCAST, SNOOP, DONE, back to IDLE
  task automatic run_txn(input string nm, input logic [NP*W-1:0] e,
                         input logic [NP*W-1:0] e_after, input logic [1:0] own,
                         input logic [W-1:0] word, input logic [NP-1:0] wen,
                         input logic [NP*W-1:0] wd, input logic exp_we,
                         input logic [W-1:0] wd_before, input logic [W-1:0] wd_after,
                         input logic cf_before, input logic cf_after);
    logic [NP-1:0] a;
    a = 3'b001 << own;
    run_vec(mk({nm, " bcast"}, e, '0, WD0, word, '0, 1'b0, wd_before, own, 1'b1, cf_before));
    run_vec(mk({nm, " snoop"}, e, '0, WD0, word, '0, 1'b0, wd_before, own, 1'b1, cf_before));
    run_vec(mk({nm, " done"},  e, wen, wd, IW, a, exp_we, wd_after, own, 1'b1, cf_after));
    run_vec(mk({nm, " idle"},  e_after, '0, WD0, IW, '0, 1'b0, wd_after, own, 1'b0,
               cf_after));
  endtask

  initial begin
    // Idle bus out of reset
    for (int i = 0; i < 3; i++) tbl.push_back(mk("idle", EI, '0, WD0, IW, '0, 0, '0, 0, 0, 0));
    // Single P0 request: two cycles on cdb, ack in the third
    tbl.push_back(mk("p0 bcast", E0, '0, WD0, W0, '0,     0, '0, 0, 1, 0));
    tbl.push_back(mk("p0 snoop", E0, '0, WD0, W0, '0,     0, '0, 0, 1, 0));
    tbl.push_back(mk("p0 done",  E0, '0, WD0, IW, 3'b001, 0, '0, 0, 1, 0));
    tbl.push_back(mk("p0 idle",  EI, '0, WD0, IW, '0,     0, '0, 0, 0, 0));
    // P0+P1 continuously; pointer now at 0, so P1,P0,P1,P0
    for (int t = 0; t < 4; t++) begin
      o3 = (t % 2 == 0) ? 2'd1 : 2'd0;
      w3 = (t % 2 == 0) ? W1 : W0;
      tbl.push_back(mk("rr bcast", E01, '0, WD0, w3, '0,              0, '0, o3, 1, 0));
      tbl.push_back(mk("rr snoop", E01, '0, WD0, w3, '0,              0, '0, o3, 1, 0));
      tbl.push_back(mk("rr done",  E01, '0, WD0, IW, 3'b001 << o3,    0, '0, o3, 1, 0));
      tbl.push_back(mk("rr idle",  E01, '0, WD0, IW, '0,              0, '0, o3, 0, 0));
    end
    // P1 granted, P0 writes back in the respond cycle
    tbl.push_back(mk("wb bcast", E1, '0,     WD0, W1, '0,     0, '0,         1, 1, 0));
    tbl.push_back(mk("wb snoop", E1, '0,     WD0, W1, '0,     0, '0,         1, 1, 0));
    tbl.push_back(mk("wb done",  E1, 3'b001, WD4, IW, 3'b010, 1, 22'h00000A, 1, 1, 0));
    tbl.push_back(mk("wb idle",  EI, '0,     WD0, IW, '0,     0, 22'h00000A, 1, 0, 0));
    // P0 granted and asserting its own write-back: must be ignored
    tbl.push_back(mk("self bcast", E0, '0,     WD0,  W0, '0,     0, 22'h00000A, 0, 1, 0));
    tbl.push_back(mk("self snoop", E0, '0,     WD0,  W0, '0,     0, 22'h00000A, 0, 1, 0));
    tbl.push_back(mk("self done",  E0, 3'b001, WD4B, IW, 3'b001, 0, 22'h00000A, 0, 1, 0));
    tbl.push_back(mk("self idle",  EI, '0,     WD0,  IW, '0,     0, 22'h00000A, 0, 0, 0));

    reset      = 1'b1;
    req_emit   = EI;
    wb_en_in   = '0;
    wb_data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst cdb",       64'(cdb),         64'(IW));
    chk("rst req_ack",   64'(req_ack),     64'(0));
    chk("rst mem_we",    64'(mem_we),      64'(0));
    chk("rst mem_wdata", 64'(mem_wdata),   64'(0));
    chk("rst grant_id",  64'(grant_id),    64'(0));
    chk("rst busy",      64'(busy),        64'(0));
    chk("rst conflict",  64'(wb_conflict), 64'(0));
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Pointer at 0, only P2 requests; P0 and P1 both write back
    run_txn("conf", E2, EI, 2'd2, W2, 3'b011, WD5, 1'b1, 22'h00000A, 22'h080033, 1'b0, 1'b1);
    // Conflict flag stays set across a clean transaction
    run_txn("sticky", E1, EI, 2'd1, W1, 3'b000, WD0, 1'b0, 22'h080033, 22'h080033, 1'b1, 1'b1);

    // Pointer now 1: P1 alone is granted again, reset lands in SNOOP
    run_vec(mk("abort bcast", E1, '0, WD0, W1, '0, 0, 22'h080033, 1, 1, 1));
    run_vec(mk("abort snoop", E1, '0, WD0, W1, '0, 0, 22'h080033, 1, 1, 1));
    wb_en_in   = 3'b001;
    wb_data_in = WD4;
    reset      = 1'b1;
    #1;
    chk("async cdb",      64'(cdb),         64'(IW));
    chk("async busy",     64'(busy),        64'(0));
    chk("async conflict", 64'(wb_conflict), 64'(0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      chk("inrst req_ack", 64'(req_ack), 64'(0));
      chk("inrst mem_we",  64'(mem_we),  64'(0));
      chk("inrst cdb",     64'(cdb),     64'(IW));
    end
    wb_en_in   = '0;
    wb_data_in = '0;
    req_emit   = EALL;
    reset      = 1'b0;
    // Without the reset P2 would win next; with it, P0 first then rotation
    run_txn("post0", EALL, EALL, 2'd0, W0, '0, WD0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_txn("post1", EALL, EALL, 2'd1, W1, '0, WD0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_txn("post2", EALL, EALL, 2'd2, W2, '0, WD0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_txn("post3", EALL, EI,   2'd0, W0, '0, WD0, 1'b0, '0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
